seven_seg_scan_driver: RTL and testbench

//  Time-multiplexed driver for an N-digit common-anode 7-segment display.
//  - Scans one digit per slot and decodes its 4-bit nibble to hex segments (0-F).
//  - Double-buffers the input word so that updates land only on frame boundaries, with no tearing.
//  - Sits between the user datapath and board pins, replacing the per-digit static decoder.

---
 rtl/seven_seg_scan_driver.sv | 165 ++++++++++++++++
 tb/tb_seven_seg_scan_driver.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/seven_seg_scan_driver.sv
// seven_seg_scan_driver: time-multiplexed N-digit common-anode 7-segment driver.
// Scans one digit per slot and decodes each nibble to hex segments.
// The display word is double-buffered so updates land only on frame boundaries.
// Optional macro SEVSEG_DP_EN adds a per-digit decimal-point input (dp_in).
module seven_seg_scan_driver #(
    parameter int NUM_DIGITS   = 8,
    parameter int REFRESH_DIV  = 100000,
    parameter int BLANK_CYCLES = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] digits_in,
    input  logic [NUM_DIGITS-1:0]   digit_en,
`ifdef SEVSEG_DP_EN
    input  logic [NUM_DIGITS-1:0]   dp_in,
`endif
    output logic [NUM_DIGITS-1:0]   an,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic                    frame_start
);

    localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK_CYCLES);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);

    // Reject configurations that cannot scan or would never light a digit.
    if (NUM_DIGITS < 2 || REFRESH_DIV <= BLANK_CYCLES) begin : g_param_check
        $error("seven_seg_scan_driver: need NUM_DIGITS>=2 and REFRESH_DIV>BLANK_CYCLES");
    end

    // Active-low hex decode, segment order {G,F,E,D,C,B,A}.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        case (nib)
            4'h0:    return 7'h40;
            4'h1:    return 7'h79;
            4'h2:    return 7'h24;
            4'h3:    return 7'h30;
            4'h4:    return 7'h19;
            4'h5:    return 7'h12;
            4'h6:    return 7'h02;
            4'h7:    return 7'h78;
            4'h8:    return 7'h00;
            4'h9:    return 7'h10;
            4'hA:    return 7'h08;
            4'hB:    return 7'h03;
            4'hC:    return 7'h46;
            4'hD:    return 7'h21;
            4'hE:    return 7'h06;
            default: return 7'h0E;
        endcase
    endfunction

    logic [CNT_W-1:0]        cnt;
    logic [IDX_W-1:0]        idx;
    logic [4*NUM_DIGITS-1:0] pend_digits, act_digits;
    logic [NUM_DIGITS-1:0]   pend_en, act_en;
    logic                    wrap_p0;
    logic                    lit_p0;
    logic [3:0]              nib_p0;
    logic [NUM_DIGITS-1:0]   an_p0;
    logic [6:0]              seg_p0;

    // Last cycle of the last slot: the frame boundary.
    assign wrap_p0 = (cnt == CNT_LAST) && (idx == IDX_LAST);

    // Slot counter and digit index; index advances when the slot counter wraps.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
            idx <= '0;
        end else if (cnt == CNT_LAST) begin
            cnt <= '0;
            idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // Pending buffer takes load; active buffer copies pending (old value) on the frame boundary.
    always_ff @(posedge clk) begin
        if (rst) begin
            pend_digits <= '0;
            pend_en     <= '0;
            act_digits  <= '0;
            act_en      <= '0;
        end else begin
            if (load) begin
                pend_digits <= digits_in;
                pend_en     <= digit_en;
            end
            if (wrap_p0) begin
                act_digits <= pend_digits;
                act_en     <= pend_en;
            end
        end
    end

    // Stage p0: decode current (idx, cnt, active) into pin values.
    always_comb begin
        nib_p0 = act_digits[4*idx +: 4];
        lit_p0 = (cnt >= CNT_BLANK) && act_en[idx];
        an_p0  = '1;
        if (lit_p0) begin
            an_p0[idx] = 1'b0;
        end
        seg_p0 = lit_p0 ? hex_to_seg(nib_p0) : 7'h7F;
    end

    // Stage p1: registered pins, one cycle behind the scan state.
    always_ff @(posedge clk) begin
        if (rst) begin
            an          <= '1;
            seg         <= 7'h7F;
            frame_start <= 1'b0;
        end else begin
            an          <= an_p0;
            seg         <= seg_p0;
            frame_start <= wrap_p0;
        end
    end

`ifdef SEVSEG_DP_EN
    logic [NUM_DIGITS-1:0] pend_dp, act_dp;
    logic                  dp_p0;

    // Decimal points ride the same double buffer as the digits.
    always_ff @(posedge clk) begin
        if (rst) begin
            pend_dp <= '0;
            act_dp  <= '0;
        end else begin
            if (load) begin
                pend_dp <= dp_in;
            end
            if (wrap_p0) begin
                act_dp <= pend_dp;
            end
        end
    end

    // Stage p0: decimal point is shown only while the anode is lit.
    always_comb begin
        dp_p0 = 1'b1;
        if (lit_p0) begin
            dp_p0 = ~act_dp[idx];
        end
    end

    // Stage p1: registered decimal-point pin.
    always_ff @(posedge clk) begin
        if (rst) begin
            dp <= 1'b1;
        end else begin
            dp <= dp_p0;
        end
    end
`else
    assign dp = 1'b1;
`endif

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// Scoreboard bench for seven_seg_scan_driver (NUM_DIGITS=4, REFRESH_DIV=4, BLANK_CYCLES=1).
// Expected pin values are queued with the cycle number they must appear on.
module tb_seven_seg_scan_driver;

    localparam int ND = 4;
`ifdef SEVSEG_DP_EN
    localparam bit DP_ON = 1'b1;
`else
    localparam bit DP_ON = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          load;
    logic [4*ND-1:0] digits_in;
    logic [ND-1:0] digit_en;
    logic [ND-1:0] dp_in;
    logic [ND-1:0] an;
    logic [6:0]    seg;
    logic          dp;
    logic          frame_start;

    seven_seg_scan_driver #(
        .NUM_DIGITS  (ND),
        .REFRESH_DIV (4),
        .BLANK_CYCLES(1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .load       (load),
        .digits_in  (digits_in),
        .digit_en   (digit_en),
`ifdef SEVSEG_DP_EN
        .dp_in      (dp_in),
`endif
        .an         (an),
        .seg        (seg),
        .dp         (dp),
        .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          cyc;
        logic [3:0]  an;
        logic [6:0]  seg;
        logic        dp;
        logic        fs;
        string       name;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    function automatic void expect_at(input int c, input logic [3:0] a,
                                      input logic [6:0] s, input logic f);
        exp_t e;
        e.cyc  = c;
        e.an   = a;
        e.seg  = s;
        e.dp   = (DP_ON && a == 4'b1101) ? 1'b0 : 1'b1;
        e.fs   = f;
        e.name = $sformatf("cyc%0d", c);
        sb_q.push_back(e);
    endfunction

    // Monitor: compare pins against every expectation due on this cycle.
    exp_t m;
    always @(negedge clk) begin
        while (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
            m = sb_q.pop_front();
            n_checks++;
            if (m.cyc != cyc || an !== m.an || seg !== m.seg || dp !== m.dp || frame_start !== m.fs)
                $display("FAIL %s: got an=%h seg=%h dp=%b fs=%b at cyc %0d, expected an=%h seg=%h dp=%b fs=%b",
                         m.name, an, seg, dp, frame_start, cyc, m.an, m.seg, m.dp, m.fs);
            else
                n_pass++;
        end
    end

    task automatic at_cyc(input int k);
        while (cyc != k) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        rst       = 1'b1;
        load      = 1'b0;
        digits_in = '0;
        digit_en  = '0;
        dp_in     = 4'b0010;

        // Reset state and the blank first frame; first pulse 16 cycles after rst drops.
        expect_at(1,  4'hF, 7'h7F, 1'b0);
        expect_at(3,  4'hF, 7'h7F, 1'b0);
        expect_at(10, 4'hF, 7'h7F, 1'b0);
        expect_at(18, 4'hF, 7'h7F, 1'b0);
        expect_at(19, 4'hF, 7'h7F, 1'b1);
        expect_at(20, 4'hF, 7'h7F, 1'b0);
        at_cyc(3);
        rst = 1'b0;

        // Load 1234, all digits enabled: shown from the frame after the first pulse.
        at_cyc(5);
        load = 1'b1; digits_in = 16'h1234; digit_en = 4'hF;
        expect_at(21, 4'hE, 7'h19, 1'b0);
        expect_at(23, 4'hE, 7'h19, 1'b0);
        expect_at(24, 4'hF, 7'h7F, 1'b0);
        expect_at(25, 4'hD, 7'h30, 1'b0);
        expect_at(29, 4'hB, 7'h24, 1'b0);
        expect_at(33, 4'h7, 7'h79, 1'b0);
        expect_at(35, 4'h7, 7'h79, 1'b1);
        at_cyc(6);
        load = 1'b0;

        // Disable digit 2 mid-frame: takes effect on the next frame only.
        at_cyc(22);
        load = 1'b1; digit_en = 4'b1011;
        expect_at(36, 4'hF, 7'h7F, 1'b0);
        expect_at(37, 4'hE, 7'h19, 1'b0);
        expect_at(41, 4'hD, 7'h30, 1'b0);
        expect_at(45, 4'hF, 7'h7F, 1'b0);
        expect_at(47, 4'hF, 7'h7F, 1'b0);
        expect_at(49, 4'h7, 7'h79, 1'b0);
        at_cyc(23);
        load = 1'b0;

        // Load ABCD mid-frame: 1234 stays until the boundary, then ABCD.
        at_cyc(40);
        load = 1'b1; digits_in = 16'hABCD; digit_en = 4'hF;
        expect_at(51, 4'h7, 7'h79, 1'b1);
        expect_at(53, 4'hE, 7'h21, 1'b0);
        expect_at(57, 4'hD, 7'h46, 1'b0);
        expect_at(61, 4'hB, 7'h03, 1'b0);
        expect_at(65, 4'h7, 7'h08, 1'b0);
        at_cyc(41);
        load = 1'b0;

        // Load in the wrap cycle: active takes old pending, 5678 shows a frame later.
        at_cyc(66);
        load = 1'b1; digits_in = 16'h5678;
        expect_at(67, 4'h7, 7'h08, 1'b1);
        expect_at(69, 4'hE, 7'h21, 1'b0);
        expect_at(83, 4'h7, 7'h08, 1'b1);
        expect_at(85, 4'hE, 7'h00, 1'b0);
        expect_at(89, 4'hD, 7'h78, 1'b0);
        expect_at(91, 4'hD, 7'h78, 1'b0);
        expect_at(92, 4'hF, 7'h7F, 1'b0);
        at_cyc(67);
        load = 1'b0;

        // Reset mid digit-2 slot: reset pins next cycle, buffers cleared, scan restarts.
        at_cyc(92);
        rst = 1'b1;
        expect_at(93,  4'hF, 7'h7F, 1'b0);
        expect_at(94,  4'hF, 7'h7F, 1'b0);
        expect_at(97,  4'hF, 7'h7F, 1'b0);
        expect_at(99,  4'hF, 7'h7F, 1'b0);
        expect_at(108, 4'hF, 7'h7F, 1'b0);
        expect_at(109, 4'hF, 7'h7F, 1'b1);
        expect_at(110, 4'hF, 7'h7F, 1'b0);
        at_cyc(93);
        rst = 1'b0;

        // Reload after reset: 00F0 appears after the restarted frame boundary.
        at_cyc(100);
        load = 1'b1; digits_in = 16'h00F0; digit_en = 4'hF;
        expect_at(111, 4'hE, 7'h40, 1'b0);
        expect_at(115, 4'hD, 7'h0E, 1'b0);
        expect_at(119, 4'hB, 7'h40, 1'b0);
        at_cyc(101);
        load = 1'b0;

        at_cyc(125);
        n_checks++;
        if (sb_q.size() != 0)
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb_q.size());
        else
            n_pass++;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
